// File: rtl/fetch_mem_arbiter.sv
// Fetch/memory arbiter for a shared single-port SRAM with wait-state sequencing.
// Optional one-entry fetch hit buffer enabled by defining FETCH_HIT_BUF_EN.
module fetch_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SRAM_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_abort,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_mem,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    IF_ACC,
    MEM_ACC,
    IF_RESP,
    MEM_RESP
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(SRAM_WAIT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              abort_q, abort_d;
  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;

`ifdef FETCH_HIT_BUF_EN
  logic              buf_v_q, buf_v_d;
  logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  always_comb begin
    buf_v_d    = buf_v_q;
    buf_tag_d  = buf_tag_q;
    buf_data_d = buf_data_q;
    if (state_q == IF_ACC && cnt_q == 4'd0 &&
        !(abort_q || if_abort)) begin
      buf_v_d    = 1'b1;
      buf_tag_d  = addr_q;
      buf_data_d = sram_rdata;
    end
    // a store to the buffered word makes the copy stale
    if (state_q == IDLE && mem_req && mem_we &&
        mem_addr == buf_tag_q) begin
      buf_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v_q    <= 1'b0;
      buf_tag_q  <= '0;
      buf_data_q <= '0;
    end else begin
      buf_v_q    <= buf_v_d;
      buf_tag_q  <= buf_tag_d;
      buf_data_q <= buf_data_d;
    end
  end

  assign buf_hit  = buf_v_q && (if_addr == buf_tag_q);
  assign buf_data = buf_data_q;
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    en_d        = en_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    abort_d     = abort_q;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (mem_req) begin
          state_d = MEM_ACC;
          en_d    = 1'b1;
          we_d    = mem_we;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          cnt_d   = CNT_INIT;
        end else if (if_req) begin
          if (buf_hit) begin
            state_d    = IF_RESP;
            if_rdata_d = buf_data;
          end else begin
            state_d = IF_ACC;
            en_d    = 1'b1;
            we_d    = 1'b0;
            addr_d  = if_addr;
            cnt_d   = CNT_INIT;
          end
        end
      end
      IF_ACC: begin
        if (if_abort) abort_d = 1'b1;
        if (cnt_q == 4'd0) begin
          en_d = 1'b0;
          we_d = 1'b0;
          // an aborted fetch finishes its SRAM cycle but is dropped
          if (abort_q || if_abort) begin
            state_d = IDLE;
            abort_d = 1'b0;
          end else begin
            state_d    = IF_RESP;
            if_rdata_d = sram_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEM_ACC: begin
        if (cnt_q == 4'd0) begin
          en_d    = 1'b0;
          we_d    = 1'b0;
          state_d = MEM_RESP;
          if (!we_q) mem_rdata_d = sram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      IF_RESP:  state_d = IDLE;
      MEM_RESP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      abort_q     <= abort_d;
    end
  end

  assign if_ready   = (state_q == IF_RESP) && !if_abort;
  assign mem_ready  = (state_q == MEM_RESP);
  assign freeze_mem = mem_req & ~mem_ready;
  assign freeze_if  = (if_req & ~if_ready) | freeze_mem;

  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;
  assign sram_en    = en_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule
